// File: rtl/ahb_pkg.sv
// Shared AHB-Lite bus types used by AHB slaves in this codebase.
package ahb_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } ahb_trans_t;

  typedef enum logic [2:0] {
    SIZE_8, SIZE_16, SIZE_32, SIZE_64, SIZE_128, SIZE_256, SIZE_512, SIZE_1024
  } ahb_size_t;

  typedef enum logic [2:0] {
    BURST_SINGLE, BURST_INCR, BURST_WRAP4, BURST_INCR4,
    BURST_WRAP8, BURST_INCR8, BURST_WRAP16, BURST_INCR16
  } ahb_burst_t;

  typedef enum logic {PROT_OPCODE = 1'b0, PROT_DATA = 1'b1} ahb_prot_0_t;
  typedef enum logic {PROT_USER = 1'b0, PROT_PRIVILEGED = 1'b1} ahb_prot_1_t;
  typedef enum logic {PROT_NONBUFFERABLE = 1'b0, PROT_BUFFERABLE = 1'b1} ahb_prot_2_t;
  typedef enum logic {PROT_NONCACHEABLE = 1'b0, PROT_CACHEABLE = 1'b1} ahb_prot_3_t;

  typedef struct packed {
    ahb_prot_3_t prot_3;
    ahb_prot_2_t prot_2;
    ahb_prot_1_t prot_1;
    ahb_prot_0_t prot_0;
  } ahb_prot_t;

  typedef enum logic {RESP_OKAY = 1'b0, RESP_ERROR = 1'b1} ahb_resp_t;

endpackage

// File: rtl/apb_pkg.sv
// Shared APB definitions: PPROT bit positions.
package apb_pkg;

  localparam int unsigned PPROT_W      = 3;
  localparam int unsigned PPROT_PRIV   = 0;
  localparam int unsigned PPROT_NONSEC = 1;
  localparam int unsigned PPROT_INSTR  = 2;

endpackage

// File: rtl/ahb2apb_bridge_if.sv
// AHB-Lite slave side and APB master side of the bridge in one bundle.
interface ahb2apb_bridge_if
  import ahb_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
) ();

  logic                    hsel_i;
  logic [ADDR_WIDTH-1:0]   haddr_i;
  ahb_trans_t              htrans_i;
  ahb_size_t               hsize_i;
  ahb_burst_t              hburst_i;
  ahb_prot_t               hprot_i;
  logic                    hwrite_i;
  logic [DATA_WIDTH-1:0]   hwdata_i;
  logic                    hready_i;
  logic                    hreadyout_o;
  ahb_resp_t               hresp_o;
  logic [DATA_WIDTH-1:0]   hrdata_o;

  logic                    psel_o;
  logic                    penable_o;
  logic                    pwrite_o;
  logic [ADDR_WIDTH-1:0]   paddr_o;
  logic [DATA_WIDTH-1:0]   pwdata_o;
  logic [DATA_WIDTH/8-1:0] pstrb_o;
  logic [2:0]              pprot_o;
  logic                    pready_i;
  logic [DATA_WIDTH-1:0]   prdata_i;
  logic                    pslverr_i;

  // Bridge view: AHB slave, APB master.
  modport slave (
    input  hsel_i, haddr_i, htrans_i, hsize_i, hburst_i, hprot_i, hwrite_i,
           hwdata_i, hready_i, pready_i, prdata_i, pslverr_i,
    output hreadyout_o, hresp_o, hrdata_o, psel_o, penable_o, pwrite_o,
           paddr_o, pwdata_o, pstrb_o, pprot_o
  );

  modport master (
    output hsel_i, haddr_i, htrans_i, hsize_i, hburst_i, hprot_i, hwrite_i,
           hwdata_i, hready_i, pready_i, prdata_i, pslverr_i,
    input  hreadyout_o, hresp_o, hrdata_o, psel_o, penable_o, pwrite_o,
           paddr_o, pwdata_o, pstrb_o, pprot_o
  );

endinterface

// File: rtl/ahb_wstrb_gen.sv
// Byte-lane mask for an AHB transfer: lanes covered by the size-aligned
// access containing addr, little-endian.
module ahb_wstrb_gen
  import ahb_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  localparam int unsigned NB        = DATA_WIDTH / 8,
  localparam int unsigned OFF_W     = (NB > 1) ? $clog2(NB) : 1
) (
  input  ahb_size_t         size,
  input  logic [OFF_W-1:0]  addr,
  output logic [NB-1:0]     strb
);

  int unsigned nbytes;
  int unsigned base;

  always_comb begin
    nbytes = 32'd1 << size;
    base   = (32'(addr) & ~(nbytes - 32'd1)) % NB;
    strb   = '0;
    for (int unsigned i = 0; i < NB; i++) begin
      strb[i] = (i >= base) && (i < base + nbytes);
    end
  end

endmodule

// File: rtl/ahb2apb_bridge.sv
// AHB-Lite to APB3/4 bridge: one APB transfer per accepted AHB beat,
// with two-cycle ERROR response for APB slave errors and oversized requests.
module ahb2apb_bridge
  import ahb_pkg::*;
  import apb_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
) (
  input logic           clk_i,
  input logic           rst_i,
  ahb2apb_bridge_if.slave bus
);

  localparam int unsigned NB       = DATA_WIDTH / 8;
  localparam int unsigned OFF_W    = (NB > 1) ? $clog2(NB) : 1;
  localparam int unsigned MAX_SIZE = $clog2(NB);

  typedef enum logic [2:0] {IDLE, LATCH, SETUP, ACCESS, ERR1, ERR2} state_t;

  state_t                state, state_nxt;
  logic                  accept, size_ok, load, rd_done;
  logic                  hreadyout, psel, penable;
  ahb_resp_t             hresp;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic                  write_q;
  ahb_size_t             size_q;
  logic [PPROT_W-1:0]    pprot_q;
  logic [DATA_WIDTH-1:0] pwdata_q, hrdata_q;
  logic [NB-1:0]         strb;
  logic                  unused_ok;

  assign accept  = bus.hsel_i && bus.hready_i &&
                   (bus.htrans_i == HTRANS_NONSEQ || bus.htrans_i == HTRANS_SEQ);
  assign size_ok = 32'(bus.hsize_i) <= MAX_SIZE;

  always_ff @(posedge clk_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    hreadyout = 1'b1;
    hresp     = RESP_OKAY;
    psel      = 1'b0;
    penable   = 1'b0;
    case (state)
      IDLE: begin
        if (accept) state_nxt = size_ok ? LATCH : ERR1;
      end
      LATCH: begin
        hreadyout = 1'b0;
        state_nxt = SETUP;
      end
      SETUP: begin
        hreadyout = 1'b0;
        psel      = 1'b1;
        state_nxt = ACCESS;
      end
      ACCESS: begin
        hreadyout = 1'b0;
        psel      = 1'b1;
        penable   = 1'b1;
        if (bus.pready_i) state_nxt = bus.pslverr_i ? ERR1 : IDLE;
      end
      ERR1: begin
        hreadyout = 1'b0;
        hresp     = RESP_ERROR;
        state_nxt = ERR2;
      end
      ERR2: begin
        hresp = RESP_ERROR;
        if (accept) state_nxt = size_ok ? LATCH : ERR1;
        else        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // LATCH is only entered from an address phase accepted in IDLE or ERR2.
  assign load    = (state_nxt == LATCH);
  assign rd_done = (state == ACCESS) && (state_nxt == IDLE) && !write_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      addr_q   <= '0;
      write_q  <= 1'b0;
      size_q   <= SIZE_8;
      pprot_q  <= '0;
      pwdata_q <= '0;
      hrdata_q <= '0;
    end else begin
      if (load) begin
        addr_q                <= bus.haddr_i;
        write_q               <= bus.hwrite_i;
        size_q                <= bus.hsize_i;
        pprot_q[PPROT_PRIV]   <= (bus.hprot_i.prot_1 == PROT_PRIVILEGED);
        pprot_q[PPROT_NONSEC] <= 1'b0;
        pprot_q[PPROT_INSTR]  <= (bus.hprot_i.prot_0 == PROT_OPCODE);
      end
      if (state == LATCH) pwdata_q <= bus.hwdata_i;
      if (rd_done)        hrdata_q <= bus.prdata_i;
    end
  end

  ahb_wstrb_gen #(.DATA_WIDTH(DATA_WIDTH)) u_wstrb (
    .size (size_q),
    .addr (addr_q[OFF_W-1:0]),
    .strb (strb)
  );

  assign bus.hreadyout_o = hreadyout;
  assign bus.hresp_o     = hresp;
  assign bus.hrdata_o    = hrdata_q;
  assign bus.psel_o      = psel;
  assign bus.penable_o   = penable;
  assign bus.pwrite_o    = write_q;
  assign bus.paddr_o     = addr_q;
  assign bus.pwdata_o    = pwdata_q;
  assign bus.pstrb_o     = write_q ? strb : '0;
  assign bus.pprot_o     = pprot_q;

  assign unused_ok = ^{bus.hburst_i, bus.hprot_i.prot_2, bus.hprot_i.prot_3};

endmodule

// File: tb/tb_ahb2apb_bridge.sv
// Directed + random bench for ahb2apb_bridge, checked against a byte-level
// memory model and transaction timing rules.
module tb_ahb2apb_bridge;
  import ahb_pkg::*;

  typedef struct {
    logic [31:0] addr;
    logic        wr;
    logic [2:0]  sz;
    logic [31:0] wd;
    logic [3:0]  prot;
    int unsigned nw;
    logic        err;
  } xfer_t;

  logic clk, rst;
  int unsigned errors = 0, checks = 0, cyc = 0;
  int unsigned cfg_wait = 0;
  logic        cfg_err = 1'b0;
  logic [31:0] exp_hrdata;
  bit [7:0]    model_mem [int unsigned];
  bit [31:0]   slave_mem [int unsigned];
  logic [3:0]  last_pstrb;
  logic [31:0] last_pwdata;
  logic [2:0]  last_pprot;
  int unsigned last_psel_n, last_access_n, last_err_n;

  ahb2apb_bridge_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

  ahb2apb_bridge #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  assign bus.hready_i = bus.hreadyout_o;

  initial begin clk = 1'b0; forever #5 clk = ~clk; end
  initial begin forever begin @(posedge clk); cyc++; end end
  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic xfer_t mk(input logic [31:0] a, input logic w, input logic [2:0] s,
                               input logic [31:0] d, input logic [3:0] p,
                               input int unsigned n, input logic e);
    xfer_t t;
    t.addr = a; t.wr = w; t.sz = s; t.wd = d; t.prot = p; t.nw = n; t.err = e;
    return t;
  endfunction

  // Byte lanes touched by the naturally aligned access containing a.
  function automatic logic [3:0] lanes(input logic [31:0] a, input logic [2:0] sz);
    int unsigned n, base;
    logic [3:0] m;
    n = 1 << sz;
    base = a & ~(n - 1);
    m = '0;
    for (int unsigned k = 0; k < n; k++) m[(base + k) % 4] = 1'b1;
    return m;
  endfunction

  function automatic logic [31:0] model_word(input logic [31:0] a);
    logic [31:0] w;
    int unsigned k;
    for (int unsigned b = 0; b < 4; b++) begin
      k = (a & ~32'd3) + b;
      w[8*b +: 8] = model_mem.exists(k) ? model_mem[k] : 8'h00;
    end
    return w;
  endfunction

  // APB completer backed by its own word memory, written through the DUT strobes.
  initial begin : apb_slave
    int unsigned waited, key;
    logic [31:0] w;
    waited = 0;
    bus.pready_i = 1'b0; bus.pslverr_i = 1'b0; bus.prdata_i = '0;
    forever begin
      @(posedge clk); #1;
      if (bus.psel_o === 1'b1 && bus.penable_o === 1'b1) begin
        if (waited >= cfg_wait) begin
          key = bus.paddr_o >> 2;
          w = slave_mem.exists(key) ? slave_mem[key] : 32'h0;
          bus.prdata_i  = w;
          bus.pready_i  = 1'b1;
          bus.pslverr_i = cfg_err;
          if (bus.pwrite_o && !cfg_err) begin
            for (int unsigned b = 0; b < 4; b++)
              if (bus.pstrb_o[b]) w[8*b +: 8] = bus.pwdata_o[8*b +: 8];
            slave_mem[key] = w;
          end
          waited = 0;
        end else begin
          bus.pready_i = 1'b0; bus.pslverr_i = 1'b0;
          waited++;
        end
      end else begin
        bus.pready_i = 1'b0; bus.pslverr_i = 1'b0;
        waited = 0;
      end
    end
  end

  task automatic addr_phase(input xfer_t t, input ahb_trans_t tr, input ahb_burst_t bu);
    cfg_wait     = t.nw;
    cfg_err      = t.err;
    bus.hsel_i   = 1'b1;
    bus.htrans_i = tr;
    bus.hburst_i = bu;
    bus.haddr_i  = t.addr;
    bus.hwrite_i = t.wr;
    bus.hsize_i  = ahb_size_t'(t.sz);
    bus.hprot_i  = ahb_prot_t'(t.prot);
  endtask

  task automatic data_phase(input xfer_t t);
    logic oversize;
    int unsigned low, psel_n, acc_n, err_n;
    logic [3:0] exp_strb;
    logic [2:0] exp_prot;
    oversize = (t.sz > 3'd2);
    exp_strb = t.wr ? lanes(t.addr, t.sz) : 4'b0000;
    exp_prot = 3'b000;
    if (t.prot[1])  exp_prot[0] = 1'b1;
    if (!t.prot[0]) exp_prot[2] = 1'b1;
    @(posedge clk); #1;
    bus.hsel_i = 1'b0; bus.htrans_i = HTRANS_IDLE; bus.hwdata_i = t.wd;
    low = 0; psel_n = 0; acc_n = 0; err_n = 0;
    while (bus.hreadyout_o !== 1'b1 && low < 64) begin
      low++;
      if (bus.hresp_o === RESP_ERROR) err_n++;
      if (bus.psel_o === 1'b1) begin
        psel_n++;
        if (bus.penable_o === 1'b1) acc_n++;
        check("penable", bus.penable_o, psel_n > 1);
        check("paddr", bus.paddr_o, t.addr);
        check("pwrite", bus.pwrite_o, t.wr);
        check("pstrb", bus.pstrb_o, exp_strb);
        check("pprot", bus.pprot_o, exp_prot);
        if (t.wr) check("pwdata", bus.pwdata_o, t.wd);
        last_pstrb = bus.pstrb_o; last_pwdata = bus.pwdata_o; last_pprot = bus.pprot_o;
      end else begin
        check("penable_idle", bus.penable_o, 1'b0);
      end
      @(posedge clk); #1;
    end
    if (bus.hresp_o === RESP_ERROR) err_n++;
    check("low_cycles", low, oversize ? 1 : 3 + t.nw + (t.err ? 1 : 0));
    check("psel_cycles", psel_n, oversize ? 0 : 2 + t.nw);
    check("err_cycles", err_n, (oversize || t.err) ? 2 : 0);
    if (!oversize && !t.err) begin
      if (t.wr) begin
        for (int unsigned k = 0; k < 4; k++)
          if (exp_strb[k]) model_mem[(t.addr & ~32'd3) + k] = t.wd[8*k +: 8];
      end else begin
        exp_hrdata = model_word(t.addr);
      end
    end
    check("hrdata", bus.hrdata_o, exp_hrdata);
    last_psel_n = psel_n; last_access_n = acc_n; last_err_n = err_n;
  endtask

  initial begin : main
    xfer_t t;
    int unsigned start [4];
    int unsigned n;
    rst = 1'b1;
    bus.hsel_i = 1'b0; bus.htrans_i = HTRANS_IDLE; bus.haddr_i = '0;
    bus.hwrite_i = 1'b0; bus.hsize_i = SIZE_8; bus.hburst_i = BURST_SINGLE;
    bus.hprot_i = '0; bus.hwdata_i = '0;
    exp_hrdata = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_hreadyout", bus.hreadyout_o, 1'b1);
    check("rst_hresp", bus.hresp_o, RESP_OKAY);
    check("rst_hrdata", bus.hrdata_o, 0);
    check("rst_psel", bus.psel_o, 0);
    check("rst_penable", bus.penable_o, 0);
    check("rst_pwrite", bus.pwrite_o, 0);
    check("rst_paddr", bus.paddr_o, 0);
    check("rst_pwdata", bus.pwdata_o, 0);
    check("rst_pstrb", bus.pstrb_o, 0);
    check("rst_pprot", bus.pprot_o, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    t = mk(32'h100, 1'b1, 3'd2, 32'hDEADBEEF, 4'b0011, 0, 1'b0);
    addr_phase(t, HTRANS_NONSEQ, BURST_SINGLE); data_phase(t);
    check("w32_pwdata", last_pwdata, 32'hDEADBEEF);
    check("w32_pstrb", last_pstrb, 4'hF);
    check("w32_pprot", last_pprot, 3'b001);
    check("w32_psel_n", last_psel_n, 2);
    check("w32_resp", bus.hresp_o, RESP_OKAY);

    slave_mem[32'h204 >> 2] = 32'h12345678;
    for (int unsigned b = 0; b < 4; b++) model_mem[32'h204 + b] = 8'(32'h12345678 >> (8 * b));
    t = mk(32'h204, 1'b0, 3'd2, 32'h0, 4'b0001, 2, 1'b0);
    addr_phase(t, HTRANS_NONSEQ, BURST_SINGLE); data_phase(t);
    check("rd_access_n", last_access_n, 3);
    check("rd_hrdata", bus.hrdata_o, 32'h12345678);
    check("rd_ready", bus.hreadyout_o, 1'b1);

    t = mk(32'h3, 1'b1, 3'd0, 32'hA5000000, 4'b0000, 0, 1'b0);
    addr_phase(t, HTRANS_NONSEQ, BURST_SINGLE); data_phase(t);
    check("b8_pstrb", last_pstrb, 4'b1000);
    check("b8_pprot", last_pprot, 3'b100);
    t = mk(32'h2, 1'b1, 3'd1, 32'h5A5A0000, 4'b0011, 0, 1'b0);
    addr_phase(t, HTRANS_NONSEQ, BURST_SINGLE); data_phase(t);
    check("h16_pstrb", last_pstrb, 4'b1100);

    t = mk(32'h100, 1'b1, 3'd2, 32'hCAFEF00D, 4'b0001, 1, 1'b1);
    addr_phase(t, HTRANS_NONSEQ, BURST_SINGLE); data_phase(t);
    check("err_cycles_n", last_err_n, 2);
    check("err2_ready", bus.hreadyout_o, 1'b1);
    t = mk(32'h100, 1'b0, 3'd2, 32'h0, 4'b0001, 0, 1'b0);
    addr_phase(t, HTRANS_NONSEQ, BURST_SINGLE); data_phase(t);
    check("after_err_rd", bus.hrdata_o, 32'hDEADBEEF);

    for (int unsigned b = 0; b < 4; b++) begin
      if (b == 3) begin
        bus.hsel_i = 1'b1; bus.htrans_i = HTRANS_BUSY;
        @(posedge clk); #1;
        check("busy_ready", bus.hreadyout_o, 1'b1);
        check("busy_resp", bus.hresp_o, RESP_OKAY);
        check("busy_psel", bus.psel_o, 1'b0);
      end
      t = mk(32'h200 + 4 * b, 1'b0, 3'd2, 32'h0, 4'b0001, 0, 1'b0);
      start[b] = cyc;
      addr_phase(t, (b == 0) ? HTRANS_NONSEQ : HTRANS_SEQ, BURST_INCR4);
      data_phase(t);
    end
    check("burst_gap01", start[1] - start[0], 4);
    check("burst_gap12", start[2] - start[1], 4);
    check("burst_gap23_busy", start[3] - start[2], 5);

    t = mk(32'h8, 1'b1, 3'd3, 32'h11112222, 4'b0001, 0, 1'b0);
    addr_phase(t, HTRANS_NONSEQ, BURST_SINGLE); data_phase(t);
    check("oversize_psel_n", last_psel_n, 0);
    check("oversize_err_n", last_err_n, 2);

    t = mk(32'h40, 1'b0, 3'd2, 32'h0, 4'b0001, 5, 1'b0);
    addr_phase(t, HTRANS_NONSEQ, BURST_SINGLE);
    @(posedge clk); #1;
    bus.hsel_i = 1'b0; bus.htrans_i = HTRANS_IDLE;
    n = 0;
    while (!(bus.psel_o === 1'b1 && bus.penable_o === 1'b1) && n < 10) begin
      @(posedge clk); #1; n++;
    end
    check("rst_reach_access", bus.penable_o, 1'b1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_hrdata = '0;
    check("midrst_psel", bus.psel_o, 1'b0);
    check("midrst_penable", bus.penable_o, 1'b0);
    check("midrst_ready", bus.hreadyout_o, 1'b1);
    check("midrst_resp", bus.hresp_o, RESP_OKAY);
    check("midrst_hrdata", bus.hrdata_o, 0);
    @(posedge clk); #1;
    check("postrst_psel", bus.psel_o, 1'b0);
    check("postrst_ready", bus.hreadyout_o, 1'b1);

    for (int i = 0; i < 40; i++) begin
      t.sz   = 3'($urandom_range(0, 2));
      if ($urandom_range(0, 15) == 0) t.sz = 3'd3;
      t.addr = 32'($urandom_range(0, 63)) & ~((32'd1 << t.sz) - 32'd1);
      t.wr   = 1'($urandom_range(0, 1));
      t.wd   = $urandom;
      t.prot = 4'($urandom_range(0, 15));
      t.nw   = $urandom_range(0, 3);
      t.err  = ($urandom_range(0, 7) == 0);
      addr_phase(t, HTRANS_NONSEQ, BURST_SINGLE);
      data_phase(t);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ahb2apb_bridge.md
AHB2APB_BRIDGE -- requirements
Module: ahb2apb_bridge

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, address width on both buses.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, data width on both buses; legal values are 8, 16, 32 and 64.
REQ-003 SHALL have port clk_i  in  1  single clock; all logic is clocked on the rising edge.
REQ-004 SHALL have port rst_i  in  1  synchronous, active-high reset.
REQ-005 SHALL have AHB-Lite slave inputs: hsel_i 1; haddr_i ADDR_WIDTH; htrans_i ahb_trans_t; hsize_i ahb_size_t; hburst_i ahb_burst_t; hprot_i ahb_prot_t; hwrite_i 1; hwdata_i DATA_WIDTH; hready_i 1.
REQ-006 SHALL have AHB-Lite slave outputs: hreadyout_o 1; hresp_o ahb_resp_t; hrdata_o DATA_WIDTH.
REQ-007 SHALL have APB3/4 master outputs: psel_o 1; penable_o 1; pwrite_o 1; paddr_o ADDR_WIDTH; pwdata_o DATA_WIDTH; pstrb_o DATA_WIDTH/8; pprot_o 3.
REQ-008 SHALL have APB master inputs: pready_i 1; prdata_i DATA_WIDTH; pslverr_i 1.

Function
REQ-009 SHALL accept an address phase when hsel_i & hready_i are high and htrans_i is NONSEQ or SEQ, and SHALL register haddr, hwrite, hsize and hprot.
REQ-010 SHALL answer IDLE or BUSY transfers, and unselected cycles, with zero wait states and OKAY.
REQ-011 SHALL implement FSM states IDLE, LATCH, SETUP, ACCESS, ERR1 and ERR2.
REQ-012 SHALL leave IDLE for LATCH on an accepted transfer; for hsize_i wider than DATA_WIDTH it SHALL go to ERR1 with no APB access.
REQ-013 SHALL, in LATCH, drive hreadyout_o=0 and capture hwdata_i into pwdata_o; then go to SETUP.
REQ-014 SHALL, in SETUP, drive psel_o=1 and penable_o=0; then go to ACCESS.
REQ-015 SHALL, in ACCESS, drive psel_o=1 and penable_o=1, and wait while pready_i=0; paddr/pwrite/pwdata/pstrb/pprot SHALL stay stable from SETUP to the end of ACCESS.
REQ-016 SHALL, on ACCESS & pready_i & !pslverr_i, go to IDLE, register prdata_i into hrdata_o for reads, and present hreadyout_o=1 with OKAY in the next cycle.
REQ-017 SHALL, on ACCESS & pready_i & pslverr_i, go to ERR1.
REQ-018 SHALL drive ERR1 as hresp_o=ERROR, hreadyout_o=0, then go to ERR2; ERR2 SHALL drive hresp_o=ERROR, hreadyout_o=1, then go to IDLE.
REQ-019 SHALL treat IDLE and ERR2 as cycles where a new address phase may be accepted; an accepted transfer SHALL go directly to LATCH, giving back-to-back pipelining.
REQ-020 SHALL give a data-phase latency of 4 cycles with zero-wait APB, i.e. hreadyout_o is low for 3 cycles.
REQ-021 SHALL treat every burst beat as an independent APB transfer; hburst_i is ignored.
REQ-022 SHALL derive pstrb_o for writes from the registered hsize and the low address bits (byte lanes little-endian); pstrb_o SHALL be all-zero for reads.
REQ-023 SHALL set pprot_o[0] = (prot_1==PRIVILEGED), pprot_o[1] = 0, pprot_o[2] = (prot_0==OPCODE).
REQ-024 SHALL hold hrdata_o until the next read completes.
REQ-025 SHALL drive psel_o=0 and penable_o=0 in IDLE, LATCH, ERR1 and ERR2.

Reset
REQ-026 SHALL, while rst_i=1 at a clock edge, set state=IDLE, hreadyout_o=1, hresp_o=OKAY, hrdata_o=0, psel_o=0, penable_o=0, pwrite_o=0, paddr_o=0, pwdata_o=0, pstrb_o=0, pprot_o=0.
REQ-027 SHALL, when reset is asserted mid-transfer (any state), deassert psel_o and penable_o in the cycle after the reset edge and not complete the pending AHB transfer.

Structure
REQ-028 SHALL import ahb_pkg for the trans, size, burst, prot and resp types.
REQ-029 SHALL place the pprot bit-index constants in a new shared apb_pkg.
REQ-030 SHALL keep the FSM state enum local to the module.
REQ-031 SHALL implement the strobe generator (hsize + address → byte mask) as sub-module ahb_wstrb_gen, for reuse by other AHB slaves.

Verification
REQ-032 Single write: addr 0x100, SIZE_32, data 0xDEADBEEF, pready=1 → psel high 2 cycles, pwdata=0xDEADBEEF, pstrb=4'hF, hreadyout low 3 cycles, OKAY.
REQ-033 Read with 2 APB wait states: addr 0x204, prdata=0x12345678 → ACCESS lasts 3 cycles; hrdata_o=0x12345678 with hreadyout_o=1 in the next cycle.
REQ-034 Byte write: addr 0x3, SIZE_8 → pstrb=4'b1000; halfword write at addr 0x2 → pstrb=4'b1100.
REQ-035 pslverr=1 on a write → hresp_o ERROR for 2 cycles, hreadyout_o 0 then 1; a NONSEQ presented in ERR2 is accepted.
REQ-036 INCR4 read burst, back-to-back, zero-wait → 4 APB transfers, no idle cycle between accepted beats; BUSY inserted mid-burst → zero-wait OKAY.
REQ-037 SIZE_64 request with DATA_WIDTH=32 → ERROR response, psel_o never asserted; rst_i pulsed during ACCESS → psel_o=0 and hreadyout_o=1 the cycle after reset.
